// File: rtl/path_player_if.sv
// Handshake and path-memory signals between path_player and its environment.
// The master side is the player; the slave side is the solver/memory/consumer.
`timescale 1ns/1ps

interface path_player_if;
    logic       Run;
    logic [7:0] path_len;
    logic [7:0] rd_adr;
    logic       rd_en;
    logic [1:0] rd_data;
    logic [1:0] Move;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] i_pos;
    logic [3:0] j_pos;
    logic [7:0] step;
    logic       Done;
    logic       Fail;

    modport master (
        input  Run, path_len, rd_data, move_ready,
        output rd_adr, rd_en, Move, move_valid, i_pos, j_pos, step, Done, Fail
    );

    modport slave (
        output Run, path_len, rd_data, move_ready,
        input  rd_adr, rd_en, Move, move_valid, i_pos, j_pos, step, Done, Fail
    );
endinterface

// File: rtl/path_player.sv
// Replays a stored path of 2-bit move codes from a 1-cycle-latency memory,
// presenting each move over a valid/ready handshake and tracking a 16x16 position.
`timescale 1ns/1ps

module path_player (
    input logic           clk,
    input logic           RST,
    path_player_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_UPDATE,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [7:0] len_q;
    logic [7:0] adr_q;
    logic [7:0] step_q;
    logic [7:0] step_inc;
    logic [3:0] i_q;
    logic [3:0] j_q;
    logic [1:0] move_q;

    logic [4:0] i_try;
    logic [4:0] j_try;
    logic       legal;

    logic       do_start;
    logic       do_capture;
    logic       do_commit;
    logic       rd_en_c;
    logic       valid_c;
    logic       done_c;
    logic       fail_c;

    assign step_inc = step_q + 8'd1;

    // Candidate position one bit wider than the grid: bit 4 set means the move
    // left the board (underflow wraps to 5'h1F, overflow reaches 5'h10).
    always_comb begin
        i_try = {1'b0, i_q};
        j_try = {1'b0, j_q};
        case (move_q)
            2'b00:   i_try = {1'b0, i_q} - 5'd1;
            2'b01:   j_try = {1'b0, j_q} + 5'd1;
            2'b10:   j_try = {1'b0, j_q} - 5'd1;
            default: i_try = {1'b0, i_q} + 5'd1;
        endcase
        legal = ~i_try[4] & ~j_try[4];
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        do_start   = 1'b0;
        do_capture = 1'b0;
        do_commit  = 1'b0;
        rd_en_c    = 1'b0;
        valid_c    = 1'b0;
        done_c     = 1'b0;
        fail_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Run) begin
                    do_start = 1'b1;
                    state_nx = (bus.path_len == 8'd0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en_c  = 1'b1;
                state_nx = bus.Run ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!bus.Run) begin
                    state_nx = S_IDLE;
                end else begin
                    do_capture = 1'b1;
                    state_nx   = S_PRESENT;
                end
            end
            S_PRESENT: begin
                valid_c = 1'b1;
                if (!bus.Run) begin
                    state_nx = S_IDLE;
                end else if (bus.move_ready) begin
                    state_nx = legal ? S_UPDATE : S_ERROR;
                end
            end
            // An abort here discards the accepted move so step/position stay consistent.
            S_UPDATE: begin
                if (!bus.Run) begin
                    state_nx = S_IDLE;
                end else begin
                    do_commit = 1'b1;
                    state_nx  = (step_inc == len_q) ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                done_c = 1'b1;
                if (!bus.Run) begin
                    state_nx = S_IDLE;
                end
            end
            S_ERROR: begin
                fail_c = 1'b1;
                if (!bus.Run) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            len_q  <= '0;
            adr_q  <= '0;
            step_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
            move_q <= '0;
        end else begin
            if (do_start) begin
                len_q  <= bus.path_len;
                adr_q  <= '0;
                step_q <= '0;
                i_q    <= '0;
                j_q    <= '0;
            end
            if (do_capture) begin
                move_q <= bus.rd_data;
            end
            if (do_commit) begin
                i_q    <= i_try[3:0];
                j_q    <= j_try[3:0];
                step_q <= step_inc;
                adr_q  <= adr_q + 8'd1;
            end
        end
    end

    assign bus.rd_adr     = adr_q;
    assign bus.rd_en      = rd_en_c;
    assign bus.Move       = move_q;
    assign bus.move_valid = valid_c;
    assign bus.i_pos      = i_q;
    assign bus.j_pos      = j_q;
    assign bus.step       = step_q;
    assign bus.Done       = done_c;
    assign bus.Fail       = fail_c;

    a_done_fail_exclusive: assert property (@(posedge clk) disable iff (RST)
        !(bus.Done && bus.Fail));

    a_adr_tracks_step: assert property (@(posedge clk) disable iff (RST)
        adr_q == step_q);

endmodule
